sid_envelope: RTL and testbench

SID_ENVELOPE -- requirements
Module: sid_envelope

---
 rtl/sid_envelope.sv | 165 ++++++++++++++++
 tb/tb_sid_envelope.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_envelope.sv
// SID-style ADSR envelope for one voice: register decode, rate ticks, exponential decay,
// and a registered signed product of the voice waveform and the envelope level.
module sid_envelope #(
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        iRstN,
  input  logic        clkEn,
  input  logic        iWE,
  input  logic [4:0]  iAddr,
  input  logic [7:0]  iData,
  input  logic [11:0] iVoice,
  output logic [7:0]  oEnv,
  output logic [1:0]  oState,
  output logic [15:0] oOut
);

  typedef enum logic [1:0] {
    StAttack       = 2'd0,
    StDecaySustain = 2'd1,
    StRelease      = 2'd2
  } state_e;

  localparam logic [4:0] AddrCtrl    = 5'(BASE_ADDR + 4);
  localparam logic [4:0] AddrAtkDec  = 5'(BASE_ADDR + 5);
  localparam logic [4:0] AddrSusRel  = 5'(BASE_ADDR + 6);

  logic        gateQ, gateD;
  logic [3:0]  attackQ, attackD, decayQ, decayD, sustainQ, sustainD, relQ, relD;
  logic [14:0] rateCntQ, rateCntD;
  logic [4:0]  expCntQ, expCntD;
  logic [7:0]  envQ, envD;
  state_e      stateQ, stateD;
  logic [15:0] outQ, outD;

  logic [3:0]         activeRate;
  logic [7:0]         target;
  logic               tick;
  logic signed [20:0] voiceS, envS, prod;
  logic               unusedProd;

  function automatic logic [14:0] ratePeriod(input logic [3:0] rate);
    unique case (rate)
      4'd0:  return 15'd9;
      4'd1:  return 15'd32;
      4'd2:  return 15'd63;
      4'd3:  return 15'd95;
      4'd4:  return 15'd149;
      4'd5:  return 15'd220;
      4'd6:  return 15'd267;
      4'd7:  return 15'd313;
      4'd8:  return 15'd392;
      4'd9:  return 15'd977;
      4'd10: return 15'd1954;
      4'd11: return 15'd3126;
      4'd12: return 15'd3907;
      4'd13: return 15'd11720;
      4'd14: return 15'd19532;
      default: return 15'd31251;
    endcase
  endfunction

  // Ticks per decay step, minus one, as a function of the current level.
  function automatic logic [4:0] expLimit(input logic [7:0] env);
    if (env > 8'd93)       return 5'd0;
    else if (env >= 8'd55) return 5'd1;
    else if (env >= 8'd27) return 5'd3;
    else if (env >= 8'd15) return 5'd7;
    else if (env >= 8'd7)  return 5'd15;
    else                   return 5'd29;
  endfunction

  always_comb begin
    gateD    = gateQ;
    attackD  = attackQ;
    decayD   = decayQ;
    sustainD = sustainQ;
    relD     = relQ;
    rateCntD = rateCntQ;
    expCntD  = expCntQ;
    envD     = envQ;
    stateD   = stateQ;

    case (stateQ)
      StAttack:       activeRate = attackQ;
      StDecaySustain: activeRate = decayQ;
      default:        activeRate = relQ;
    endcase
    target = (stateQ == StDecaySustain) ? {sustainQ, sustainQ} : 8'd0;

    // A counter already past the new period runs on to the natural 15-bit wrap.
    tick = clkEn && (rateCntQ == ratePeriod(activeRate) - 15'd1);
    if (clkEn) rateCntD = tick ? 15'd0 : rateCntQ + 15'd1;

    if (tick) begin
      if (stateQ == StAttack) begin
        if (envQ != 8'hFF) envD = envQ + 8'd1;
        if (envQ >= 8'hFE) stateD = StDecaySustain;
      end else if (expCntQ >= expLimit(envQ)) begin
        expCntD = 5'd0;
        if (envQ > target) envD = envQ - 8'd1;
      end else begin
        expCntD = expCntQ + 5'd1;
      end
    end

    // Writes land after the tick so a coincident tick used the old state and rates.
    if (iWE) begin
      if (iAddr == AddrCtrl) begin
        gateD = iData[0];
        if (iData[0] != gateQ) begin
          if (iData[0]) begin
            stateD  = StAttack;
            expCntD = 5'd0;
          end else begin
            stateD = StRelease;
          end
        end
      end else if (iAddr == AddrAtkDec) begin
        attackD = iData[7:4];
        decayD  = iData[3:0];
      end else if (iAddr == AddrSusRel) begin
        sustainD = iData[7:4];
        relD     = iData[3:0];
      end
    end

    voiceS     = 21'($signed({~iVoice[11], iVoice[10:0]}));
    envS       = {13'd0, envQ};
    prod       = voiceS * envS;
    outD       = prod[19:4];
    unusedProd = ^{prod[20], prod[3:0]};
  end

  always_ff @(posedge clk) begin
    if (!iRstN) begin
      gateQ    <= 1'b0;
      attackQ  <= 4'd0;
      decayQ   <= 4'd0;
      sustainQ <= 4'd0;
      relQ     <= 4'd0;
      rateCntQ <= 15'd0;
      expCntQ  <= 5'd0;
      envQ     <= 8'd0;
      stateQ   <= StRelease;
      outQ     <= 16'd0;
    end else begin
      gateQ    <= gateD;
      attackQ  <= attackD;
      decayQ   <= decayD;
      sustainQ <= sustainD;
      relQ     <= relD;
      rateCntQ <= rateCntD;
      expCntQ  <= expCntD;
      envQ     <= envD;
      stateQ   <= stateD;
      outQ     <= outD;
    end
  end

  assign oEnv   = envQ;
  assign oState = stateQ;
  assign oOut   = outQ;

endmodule

// File: tb/tb_sid_envelope.sv
// Bench for sid_envelope: directed ADSR scenarios plus random traffic, checked against an
// integer model of the envelope rules.
`timescale 1ns/1ps
module tb_sid_envelope;

  localparam int unsigned Base = 7;
  localparam logic [4:0] ACtrl = 5'(Base + 4);
  localparam logic [4:0] ARate = 5'(Base + 5);
  localparam logic [4:0] ASus  = 5'(Base + 6);

  logic        clk = 1'b0;
  logic        iRstN, clkEn, iWE;
  logic [4:0]  iAddr;
  logic [7:0]  iData;
  logic [11:0] iVoice;
  logic [7:0]  oEnv;
  logic [1:0]  oState;
  logic [15:0] oOut;

  int checks = 0;
  int failures = 0;

  int mGate, mAtk, mDec, mSus, mRel, mCnt, mDiv, mEnv, mState, mOut;
  int periods [16] = '{9, 32, 63, 95, 149, 220, 267, 313, 392, 977, 1954, 3126, 3907,
                       11720, 19532, 31251};

  sid_envelope #(.BASE_ADDR(Base)) dut (
    .clk(clk), .iRstN(iRstN), .clkEn(clkEn), .iWE(iWE), .iAddr(iAddr), .iData(iData),
    .iVoice(iVoice), .oEnv(oEnv), .oState(oState), .oOut(oOut)
  );

  always #5 clk = ~clk;

  function automatic int expN(input int e);
    if (e > 93) return 1;
    else if (e >= 55) return 2;
    else if (e >= 27) return 4;
    else if (e >= 15) return 8;
    else if (e >= 7) return 16;
    else return 30;
  endfunction

  // Reference model: one clock edge, using the inputs present before the edge.
  task automatic model_edge();
    int s, p, rate, nState, target;
    bit tick;
    if (!iRstN) begin
      mGate = 0; mAtk = 0; mDec = 0; mSus = 0; mRel = 0;
      mCnt = 0; mDiv = 0; mEnv = 0; mState = 2; mOut = 0;
      return;
    end
    s = int'(iVoice) - 2048;
    p = s * mEnv;
    mOut = (p >>> 4) & 32'hFFFF;
    rate = (mState == 0) ? mAtk : (mState == 1) ? mDec : mRel;
    tick = clkEn && (mCnt == periods[rate] - 1);
    if (clkEn) mCnt = tick ? 0 : (mCnt + 1) % 32768;
    nState = mState;
    if (tick) begin
      if (mState == 0) begin
        if (mEnv < 255) mEnv++;
        if (mEnv == 255) nState = 1;
      end else begin
        target = (mState == 1) ? mSus * 17 : 0;
        mDiv++;
        if (mDiv >= expN(mEnv)) begin
          mDiv = 0;
          if (mEnv > target) mEnv--;
        end
      end
    end
    if (iWE) begin
      if (iAddr == ACtrl) begin
        if (int'(iData[0]) != mGate) begin
          nState = iData[0] ? 0 : 2;
          if (iData[0]) mDiv = 0;
        end
        mGate = int'(iData[0]);
      end else if (iAddr == ARate) begin
        mAtk = int'(iData[7:4]); mDec = int'(iData[3:0]);
      end else if (iAddr == ASus) begin
        mSus = int'(iData[7:4]); mRel = int'(iData[3:0]);
      end
    end
    mState = nState;
  endtask

  task automatic step(input logic rstN, input logic we, input logic [4:0] addr,
                      input logic [7:0] data, input logic en, input logic [11:0] voice);
    iRstN = rstN; iWE = we; iAddr = addr; iData = data; clkEn = en; iVoice = voice;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, ACtrl, 8'h01, 1'b1, 12'hFFF);
    step(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 12'h800);
    checks++;
    if (oEnv !== 8'h00 || oState !== 2'd2 || oOut !== 16'h0000) begin
      failures++;
      $display("FAIL reset_init env=%h state=%0d out=%h want 00/2/0000", oEnv, oState, oOut);
    end
    step(1'b1, 1'b1, ARate, 8'h00, 1'b0, 12'h800);
    step(1'b1, 1'b1, ACtrl, 8'h01, 1'b0, 12'h800);
    for (int i = 0; i < 2000 && oEnv !== 8'h80; i++) begin
      step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 12'hFFF);
      checks++;
      if (oEnv !== 8'(mEnv) || oState !== 2'(mState) || oOut !== 16'(mOut)) begin
        failures++;
        $display("FAIL reset_climb env=%h/%h state=%0d/%0d out=%h/%h (got/want)",
                 oEnv, 8'(mEnv), oState, mState, oOut, 16'(mOut));
      end
    end
    checks++;
    if (oEnv !== 8'h80) begin
      failures++;
      $display("FAIL reset_reach80 env=%h want 80", oEnv);
    end
    step(1'b0, 1'b1, ACtrl, 8'h01, 1'b1, 12'hFFF);
    checks++;
    if (oEnv !== 8'h00 || oState !== 2'd2 || oOut !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid_attack env=%h state=%0d out=%h want 00/2/0000",
               oEnv, oState, oOut);
    end
    step(1'b1, 1'b1, ACtrl, 8'h01, 1'b0, 12'h800);
    checks++;
    if (oState !== 2'd0 || oEnv !== 8'h00) begin
      failures++;
      $display("FAIL reset_gate_cleared state=%0d env=%h want 0/00", oState, oEnv);
    end
  endtask

  task automatic test_attack();
    step(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 12'h800);
    step(1'b1, 1'b1, ARate, 8'h00, 1'b0, 12'h800);
    step(1'b1, 1'b1, ASus, 8'h00, 1'b0, 12'h800);
    step(1'b1, 1'b1, ACtrl, 8'h01, 1'b0, 12'h800);
    checks++;
    if (oState !== 2'd0 || oEnv !== 8'h00) begin
      failures++;
      $display("FAIL attack_entry state=%0d env=%h want 0/00", oState, oEnv);
    end
    for (int i = 1; i <= 2295; i++) begin
      step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 12'($urandom));
      checks++;
      if (oEnv !== 8'(mEnv) || oState !== 2'(mState) || oOut !== 16'(mOut)) begin
        failures++;
        $display("FAIL attack_track env=%h/%h state=%0d/%0d out=%h/%h (got/want)",
                 oEnv, 8'(mEnv), oState, mState, oOut, 16'(mOut));
      end
      if (i % 9 == 0) begin
        checks++;
        if (oEnv !== 8'(i / 9)) begin
          failures++;
          $display("FAIL attack_step clkEn=%0d env=%h want %h", i, oEnv, 8'(i / 9));
        end
      end
    end
    checks++;
    if (oEnv !== 8'hFF || oState !== 2'd1) begin
      failures++;
      $display("FAIL attack_done env=%h state=%0d want FF/1", oEnv, oState);
    end
  endtask

  task automatic test_multiply();
    step(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 12'hFFF);
    checks++;
    if (oOut !== 16'h7F70) begin
      failures++;
      $display("FAIL mul_max out=%h want 7F70", oOut);
    end
    iVoice = 12'h000;
    #1;
    checks++;
    if (oOut !== 16'h7F70) begin
      failures++;
      $display("FAIL mul_latency out=%h want 7F70 before the edge", oOut);
    end
    step(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 12'h000);
    checks++;
    if (oOut !== 16'h8080) begin
      failures++;
      $display("FAIL mul_min out=%h want 8080", oOut);
    end
    step(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 12'h800);
    checks++;
    if (oOut !== 16'h0000) begin
      failures++;
      $display("FAIL mul_mid out=%h want 0000", oOut);
    end
  endtask

  task automatic test_decay_sustain();
    step(1'b1, 1'b1, ASus, 8'h80, 1'b0, 12'h800);
    for (int i = 0; i < 3000 && oEnv !== 8'h88; i++) begin
      step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 12'($urandom));
      checks++;
      if (oEnv !== 8'(mEnv) || oState !== 2'(mState) || oOut !== 16'(mOut)) begin
        failures++;
        $display("FAIL decay_track env=%h/%h state=%0d/%0d out=%h/%h (got/want)",
                 oEnv, 8'(mEnv), oState, mState, oOut, 16'(mOut));
      end
    end
    checks++;
    if (oEnv !== 8'h88 || oState !== 2'd1) begin
      failures++;
      $display("FAIL decay_reach env=%h state=%0d want 88/1", oEnv, oState);
    end
    for (int i = 0; i < 2000; i++) begin
      step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 12'h800);
      checks++;
      if (oEnv !== 8'h88 || oState !== 2'd1) begin
        failures++;
        $display("FAIL sustain_hold env=%h state=%0d want 88/1", oEnv, oState);
      end
    end
  endtask

  task automatic test_release();
    int prevEnv, gap;
    bit first;
    step(1'b1, 1'b1, ACtrl, 8'h00, 1'b0, 12'h800);
    checks++;
    if (oState !== 2'd2 || oEnv !== 8'h88) begin
      failures++;
      $display("FAIL release_entry state=%0d env=%h want 2/88", oState, oEnv);
    end
    prevEnv = 'h88; gap = 0; first = 1'b1;
    for (int i = 0; i < 10000 && oEnv !== 8'h00; i++) begin
      step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 12'($urandom));
      gap++;
      checks++;
      if (oEnv !== 8'(mEnv) || oState !== 2'(mState) || oOut !== 16'(mOut)) begin
        failures++;
        $display("FAIL release_track env=%h/%h state=%0d/%0d out=%h/%h (got/want)",
                 oEnv, 8'(mEnv), oState, mState, oOut, 16'(mOut));
      end
      if (int'(oEnv) != prevEnv) begin
        if (!first) begin
          checks++;
          if (gap != 9 * expN(prevEnv)) begin
            failures++;
            $display("FAIL release_gap from=%0d gap=%0d want %0d", prevEnv, gap,
                     9 * expN(prevEnv));
          end
        end
        first = 1'b0; prevEnv = int'(oEnv); gap = 0;
      end
    end
    checks++;
    if (oEnv !== 8'h00) begin
      failures++;
      $display("FAIL release_zero env=%h want 00", oEnv);
    end
    for (int i = 0; i < 3000; i++) begin
      step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 12'h800);
      checks++;
      if (oEnv !== 8'h00 || oState !== 2'd2) begin
        failures++;
        $display("FAIL release_floor env=%h state=%0d want 00/2", oEnv, oState);
      end
    end
  endtask

  task automatic test_retrigger();
    int v1, v2;
    step(1'b1, 1'b1, ARate, 8'h00, 1'b0, 12'h800);
    step(1'b1, 1'b1, ACtrl, 8'h01, 1'b0, 12'h800);
    for (int i = 0; i < 1500 && oEnv !== 8'h60; i++) begin
      step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 12'h800);
    end
    checks++;
    if (oEnv !== 8'h60 || oState !== 2'd0) begin
      failures++;
      $display("FAIL retrig_up env=%h state=%0d want 60/0", oEnv, oState);
    end
    step(1'b1, 1'b1, ACtrl, 8'h00, 1'b0, 12'h800);
    for (int i = 0; i < 2000 && oEnv !== 8'h40; i++) begin
      step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 12'($urandom));
      checks++;
      if (oEnv !== 8'(mEnv) || oState !== 2'(mState) || oOut !== 16'(mOut)) begin
        failures++;
        $display("FAIL retrig_track env=%h/%h state=%0d/%0d out=%h/%h (got/want)",
                 oEnv, 8'(mEnv), oState, mState, oOut, 16'(mOut));
      end
    end
    checks++;
    if (oEnv !== 8'h40 || oState !== 2'd2) begin
      failures++;
      $display("FAIL retrig_down env=%h state=%0d want 40/2", oEnv, oState);
    end
    step(1'b1, 1'b1, ACtrl, 8'h01, 1'b1, 12'h800);
    checks++;
    if (oState !== 2'd0 || oEnv !== 8'h40) begin
      failures++;
      $display("FAIL retrig_gate state=%0d env=%h want 0/40", oState, oEnv);
    end
    v1 = -1; v2 = -1;
    for (int i = 0; i < 100 && v2 < 0; i++) begin
      step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 12'h800);
      if (v1 < 0 && oEnv !== 8'h40) v1 = int'(oEnv);
      else if (v1 >= 0 && int'(oEnv) != v1) v2 = int'(oEnv);
    end
    checks++;
    if (v1 != 'h41 || v2 != 'h42) begin
      failures++;
      $display("FAIL retrig_continue seq=%0h,%0h want 41,42", v1, v2);
    end
  endtask

  task automatic test_rate_wrap();
    int n;
    step(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 12'h800);
    step(1'b1, 1'b1, ARate, 8'hF0, 1'b0, 12'h800);
    step(1'b1, 1'b1, ACtrl, 8'h01, 1'b0, 12'h800);
    for (int i = 0; i < 500; i++) step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 12'h800);
    checks++;
    if (oEnv !== 8'h00 || oState !== 2'd0) begin
      failures++;
      $display("FAIL wrap_pre env=%h state=%0d want 00/0", oEnv, oState);
    end
    step(1'b1, 1'b1, ARate, 8'h00, 1'b0, 12'h800);
    n = 0;
    for (int i = 0; i < 33000 && oEnv === 8'h00; i++) begin
      step(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 12'h800);
      n++;
    end
    checks++;
    if (n != 32277 || oEnv !== 8'h01) begin
      failures++;
      $display("FAIL wrap_tick clkEn=%0d env=%h want 32277/01", n, oEnv);
    end
  endtask

  task automatic test_random();
    logic [4:0] addr;
    logic [7:0] data;
    for (int i = 0; i < 4000; i++) begin
      addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(Base + 4 + $urandom_range(0, 2));
      data = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'($urandom) & 8'h11);
      step(($urandom_range(0, 799) != 0), ($urandom_range(0, 15) == 0), addr, data,
           ($urandom_range(0, 3) != 0), 12'($urandom));
      checks++;
      if (oEnv !== 8'(mEnv) || oState !== 2'(mState) || oOut !== 16'(mOut)) begin
        failures++;
        $display("FAIL random_track cyc=%0d env=%h/%h state=%0d/%0d out=%h/%h (got/want)",
                 i, oEnv, 8'(mEnv), oState, mState, oOut, 16'(mOut));
      end
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRstN = 1'b0; clkEn = 1'b0; iWE = 1'b0; iAddr = 5'd0; iData = 8'd0; iVoice = 12'h800;
    test_reset();
    test_attack();
    test_multiply();
    test_decay_sustain();
    test_release();
    test_retrigger();
    test_rate_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
